block_scheduler: RTL and testbench
==================================

# block_scheduler

Level sequencer for the falling-block playfield. It owns a fixed pool of `block` instances ("slots") and decides when each one enters the screen and at which X lane. It also recycles each slot once its block leaves the screen or is hit, and counts the level down to completion. It sits between the game-state FSM, which issues `start_level` and `level`, and the `block` instances, whose `block_ready`, `Block_X_Center` and `Reset` inputs it drives.

## Interface
- `NUM_SLOTS`, 4: number of `block` instances managed.
- `BLOCKS_PER_LEVEL`, 16: blocks spawned per level.
- `SPAWN_GAP`, 60: base frames between spawns.
- `LFSR_SEED`, 10'h2A5: LFSR reset value; must be non-zero.

Ports:
- `frame_clk`  in  1  single clock, one tick per video frame.
- `Reset`  in  1  synchronous, active-high.
- `start_level`  in  1  one-cycle pulse; begins a level.
- `level`  in  4  current level number; sampled on accepted `start_level`.
- `slot_done`  in  NUM_SLOTS  per-slot `end_level` from `block` (block is off-screen).
- `slot_hit`  in  NUM_SLOTS  per-slot collision (OR of the slot's `Collision[0:1]`).
- `block_ready`  out  NUM_SLOTS  per-slot go signal to `block`.
- `block_x_center`  out  10*NUM_SLOTS  packed lane X per slot; slot i occupies bits [10i+9:10i].
- `block_reset`  out  NUM_SLOTS  one-cycle pulse that re-homes a block; ORed into that block's `Reset` at top level.
- `blocks_left`  out  5  blocks not yet spawned this level.
- `hits`  out  8  blocks retired by collision this level.
- `busy`  out  1  level in progress.
- `level_done`  out  1  one-cycle pulse when the level completes.

## Operation
- States: IDLE, WAIT, SPAWN, DRAIN, DONE.
- **IDLE**
  - `start_level`: load `gap_reload = max(SPAWN_GAP − 4*level, 8)`, gap counter ← 0, `blocks_left` ← BLOCKS_PER_LEVEL, `hits` ← 0, → WAIT.
  - `start_level` in any other state is ignored.
- **WAIT**
  - Gap counter decrements each frame.
  - At 0: → SPAWN if `blocks_left` ≠ 0, else → DRAIN.
- **SPAWN**
  - Pick the lowest-index free slot. For that slot: set its `active` flag, set `block_ready[i]`=1, latch `block_x_center[i] = 40 + 80*lfsr[2:0]` (range 40..600), decrement `blocks_left`, reload the gap counter, → WAIT.
  - If no slot is free, hold in SPAWN; the gap counter does not run.
- **DRAIN**
  - When no slot is active, → DONE.
- **DONE**
  - Pulse `level_done` for one cycle, → IDLE.
- **Slot retirement**, evaluated every cycle for each active slot i:
  - When `slot_hit[i]` or `slot_done[i]` is set: clear `active[i]` and `block_ready[i]`, and pulse `block_reset[i]` the next cycle.
  - `slot_hit[i]` increments `hits`, saturating at 255.
  - Both set in the same cycle counts as one hit.
  - Inputs for inactive slots are ignored.
- **Slot reuse**
  - A slot retired in cycle N is not spawn-eligible until cycle N+2, after its `block_reset` pulse.
- **LFSR**
  - 10-bit Fibonacci LFSR, taps 10 and 7 (x^10+x^7+1).
  - Advances every cycle in all states.
- **Outputs while active**
  - `block_x_center[i]` holds its latched value while `active[i]`=1; it is don't-care otherwise.

## Timing
- **Reset values** (applied at the first `frame_clk` edge with `Reset`=1, regardless of state):
  - State IDLE, all `active`=0.
  - `block_ready`=0, `block_reset`=0, `block_x_center`=all 0.
  - `blocks_left`=0, `hits`=0, `busy`=0, `level_done`=0.
  - LFSR=LFSR_SEED.
- **Latencies**
  - First spawn: `start_level` at edge N → `block_ready` rises at edge N+2 (WAIT with counter 0, then SPAWN).
  - Subsequent spawns: `gap_reload`+1 frames apart when a slot is free.
  - Retire: `slot_*` sampled at edge N → `block_ready` low after N, `block_reset` high for exactly the cycle after N+1.
- `busy` = state ∉ {IDLE}; it deasserts in the same cycle `level_done` pulses.
- **Simultaneous events**
  - Retire and spawn in the same cycle: the retired slot is not eligible for that spawn.
  - A hit on a slot in the same cycle it is spawned is ignored, because `active` was 0 when sampled.

## Configuration
- `BLOCK_SCHED_SCORE_EN`
  - Defined: the `hits` counter is implemented as described.
  - Undefined: `hits` is tied to 0 and no counter logic is generated; slot retirement behaviour is unchanged.

## Test plan
- Reset, then `start_level` with `level`=0: `block_ready[0]` rises 2 cycles later, `block_ready[1]` 61 cycles after that, `blocks_left` decrements 16→15→14.
- `level`=14: gap floors at 8; consecutive spawns are 9 frames apart.
- Hold every active slot's `slot_*` low: after 4 spawns the FSM sits in SPAWN. Pulse `slot_done[2]`: `block_reset[2]` pulses one cycle later, and slot 2 respawns one cycle after that.
- `slot_hit[1]` and `slot_done[1]` together: `hits`+=1 (0 with `BLOCK_SCHED_SCORE_EN` undefined), a single `block_reset[1]` pulse.
- Retire all 16 blocks: `level_done` is a single pulse, `busy`→0, and a second `start_level` pulse during the level is ignored.
- Assert `Reset` mid-level with 3 slots active: next cycle all outputs take their reset values and the LFSR equals 10'h2A5.

Source files
------------

// File: rtl/block_scheduler.sv
// block_scheduler: level sequencer for the falling-block playfield.
// Owns NUM_SLOTS block instances, spawns them on a frame-counted gap at
// pseudo-random X lanes, recycles them when they leave the screen or are hit,
// and signals level completion.
// Optional feature macro: BLOCK_SCHED_SCORE_EN (implements the hits counter;
// when undefined, hits is tied to zero).
module block_scheduler #(
    parameter int          NUM_SLOTS        = 4,
    parameter int          BLOCKS_PER_LEVEL = 16,
    parameter int          SPAWN_GAP        = 60,
    parameter logic [9:0]  LFSR_SEED        = 10'h2A5
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      start_level,
    input  logic [3:0]                level,
    input  logic [NUM_SLOTS-1:0]      slot_done,
    input  logic [NUM_SLOTS-1:0]      slot_hit,
    output logic [NUM_SLOTS-1:0]      block_ready,
    output logic [10*NUM_SLOTS-1:0]   block_x_center,
    output logic [NUM_SLOTS-1:0]      block_reset,
    output logic [4:0]                blocks_left,
    output logic [7:0]                hits,
    output logic                      busy,
    output logic                      level_done
);

    // Gap counter wide enough for the largest reload value.
    localparam int GAP_W = $clog2(SPAWN_GAP + 9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SPAWN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [NUM_SLOTS-1:0]      r_active;
    logic [NUM_SLOTS-1:0]      r_retire_pend;
    logic [NUM_SLOTS-1:0]      r_block_reset;
    logic [10*NUM_SLOTS-1:0]   r_x_center;
    logic [4:0]                r_blocks_left;
    logic                      r_busy;
    logic                      r_level_done;
    logic [GAP_W-1:0]          r_gap_cnt;
    logic [GAP_W-1:0]          r_gap_reload;
    logic [9:0]                r_lfsr;

    logic [NUM_SLOTS-1:0]      w_retire;
    logic [NUM_SLOTS-1:0]      w_free;
    logic [NUM_SLOTS-1:0]      w_pick;
    logic                      w_found;
    logic                      w_spawn;
    logic                      w_start;
    logic [9:0]                w_lane;

    // The counter holds "WAIT frames remaining minus one", so a reload of
    // gap-1 yields spawns exactly gap+1 frames apart and a load of 0 on
    // level start gives the two-frame first-spawn latency.
    function automatic logic [GAP_W-1:0] f_gap_reload(input logic [3:0] lvl);
        int signed g;
        g = SPAWN_GAP - 4 * int'(lvl);
        if (g < 8) g = 8;
        return GAP_W'(g - 1);
    endfunction

    assign w_start  = (r_state == S_IDLE) && start_level;
    assign w_retire = r_active & (slot_hit | slot_done);
    // A slot is reusable only once its retirement pulse has been issued.
    assign w_free   = ~r_active & ~r_retire_pend;
    assign w_spawn  = (r_state == S_SPAWN) && w_found;
    assign w_lane   = 10'd40 + 10'd80 * {7'd0, r_lfsr[2:0]};

    // Lowest-index free slot, one-hot.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_free[i] && !w_found) begin
                w_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    // Free-running lane LFSR, x^10 + x^7 + 1.
    always_ff @(posedge frame_clk) begin
        if (Reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end

    // Level FSM plus per-slot active/retire bookkeeping.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_active      <= '0;
            r_retire_pend <= '0;
            r_block_reset <= '0;
            r_x_center    <= '0;
            r_blocks_left <= '0;
            r_busy        <= 1'b0;
            r_level_done  <= 1'b0;
            r_gap_cnt     <= '0;
            r_gap_reload  <= '0;
        end else begin
            r_level_done  <= 1'b0;
            r_retire_pend <= w_retire;
            r_block_reset <= r_retire_pend;
            r_active      <= (r_active & ~w_retire) | (w_spawn ? w_pick : '0);

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_spawn && w_pick[i]) r_x_center[10*i +: 10] <= w_lane;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_level) begin
                        r_gap_reload  <= f_gap_reload(level);
                        r_gap_cnt     <= '0;
                        r_blocks_left <= 5'(BLOCKS_PER_LEVEL);
                        r_busy        <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= (r_blocks_left != 5'd0) ? S_SPAWN : S_DRAIN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                S_SPAWN: begin
                    if (w_spawn) begin
                        r_blocks_left <= r_blocks_left - 5'd1;
                        r_gap_cnt     <= r_gap_reload;
                        r_state       <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (r_active == '0) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_level_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BLOCK_SCHED_SCORE_EN
    logic [7:0]           r_hits;
    logic [NUM_SLOTS-1:0] w_hit_ret;
    logic [7:0]           w_hit_n;

    function automatic logic [7:0] f_sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // A hit and a done on the same slot retire it once, so count per slot.
    assign w_hit_ret = r_active & slot_hit;

    // Number of slots retired by collision this cycle.
    always_comb begin
        w_hit_n = 8'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_hit_n = w_hit_n + {7'd0, w_hit_ret[i]};
        end
    end

    // Saturating per-level hit counter.
    always_ff @(posedge frame_clk) begin
        if (Reset)        r_hits <= 8'd0;
        else if (w_start) r_hits <= 8'd0;
        else              r_hits <= f_sat_add(r_hits, w_hit_n);
    end

    assign hits = r_hits;
`else
    assign hits = 8'd0;
`endif

    assign block_ready    = r_active;
    assign block_x_center = r_x_center;
    assign block_reset    = r_block_reset;
    assign blocks_left    = r_blocks_left;
    assign busy           = r_busy;
    assign level_done     = r_level_done;

endmodule

// File: tb/tb_block_scheduler.sv
// Scoreboard bench for block_scheduler: directed stimulus pushes expected
// spawn / block_reset / level_done events; a monitor pops and compares them.
module tb_block_scheduler;

    localparam int         NS   = 4;
    localparam logic [9:0] SEED = 10'h2A5;
`ifdef BLOCK_SCHED_SCORE_EN
    localparam int HIT_UNIT = 1;
`else
    localparam int HIT_UNIT = 0;
`endif

    logic            frame_clk = 1'b0;
    logic            Reset;
    logic            start_level;
    logic [3:0]      level;
    logic [NS-1:0]   slot_done;
    logic [NS-1:0]   slot_hit;
    logic [NS-1:0]   block_ready;
    logic [10*NS-1:0] block_x_center;
    logic [NS-1:0]   block_reset;
    logic [4:0]      blocks_left;
    logic [7:0]      hits;
    logic            busy;
    logic            level_done;

    block_scheduler dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .start_level    (start_level),
        .level          (level),
        .slot_done      (slot_done),
        .slot_hit       (slot_hit),
        .block_ready    (block_ready),
        .block_x_center (block_x_center),
        .block_reset    (block_reset),
        .blocks_left    (blocks_left),
        .hits           (hits),
        .busy           (busy),
        .level_done     (level_done)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int cyc;
        int slot;
        int x;
        int left;
    } spawn_t;

    spawn_t spawn_q[$];
    int     rst_cyc_q[$];
    int     rst_slot_q[$];
    int     done_q[$];

    int cyc      = 0;
    int rst_edge = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Edge counter; rst_edge records the last edge that sampled Reset high.
    always @(posedge frame_clk) begin
        cyc <= cyc + 1;
        if (Reset) rst_edge <= cyc + 1;
    end

    function automatic logic [9:0] lfsr_adv(input int n);
        logic [9:0] l;
        l = SEED;
        for (int k = 0; k < n; k++) l = {l[8:0], l[9] ^ l[6]};
        return l;
    endfunction

    // Lane latched at edge e uses the LFSR value present just before e.
    function automatic int x_at(input int e);
        logic [9:0] l;
        l = lfsr_adv(e - 1 - rst_edge);
        return 40 + 80 * int'(l[2:0]);
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_spawn(input int c, input int s, input int left);
        spawn_t e;
        e.cyc  = c;
        e.slot = s;
        e.x    = x_at(c);
        e.left = left;
        spawn_q.push_back(e);
    endtask

    task automatic push_rst(input int c, input int s);
        rst_cyc_q.push_back(c);
        rst_slot_q.push_back(s);
    endtask

    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 2000) begin
            @(negedge frame_clk);
            guard++;
        end
        if (cyc != t) begin
            n_checks++;
            n_fail++;
            $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, t);
        end
    endtask

    // Monitor: compares every presented event against the scoreboard.
    initial begin
        logic [NS-1:0] prev_ready;
        spawn_t        e;
        int            ec, es, ax;
        prev_ready = '0;
        forever begin
            @(negedge frame_clk);
            if (cyc > 0) begin
                for (int i = 0; i < NS; i++) begin
                    if (block_ready[i] && !prev_ready[i]) begin
                        n_checks++;
                        ax = int'(block_x_center[10*i +: 10]);
                        if (spawn_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL spawn: unexpected spawn slot %0d at cycle %0d", i, cyc);
                        end else begin
                            e = spawn_q.pop_front();
                            if (cyc != e.cyc || i != e.slot || ax != e.x || int'(blocks_left) != e.left) begin
                                n_fail++;
                                $display("FAIL spawn: got cyc=%0d slot=%0d x=%0d left=%0d, expected cyc=%0d slot=%0d x=%0d left=%0d",
                                         cyc, i, ax, blocks_left, e.cyc, e.slot, e.x, e.left);
                            end
                        end
                    end
                    if (block_reset[i]) begin
                        n_checks++;
                        if (rst_cyc_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL block_reset: unexpected pulse slot %0d at cycle %0d", i, cyc);
                        end else begin
                            ec = rst_cyc_q.pop_front();
                            es = rst_slot_q.pop_front();
                            if (cyc != ec || i != es) begin
                                n_fail++;
                                $display("FAIL block_reset: got cyc=%0d slot=%0d, expected cyc=%0d slot=%0d", cyc, i, ec, es);
                            end
                        end
                    end
                end
                if (level_done) begin
                    n_checks++;
                    if (done_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL level_done: unexpected pulse at cycle %0d", cyc);
                    end else begin
                        ec = done_q.pop_front();
                        if (cyc != ec || busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL level_done: got cyc=%0d busy=%0b, expected cyc=%0d busy=0", cyc, busy, ec);
                        end
                    end
                end
                prev_ready = block_ready;
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, " block_ready"},    40'(block_ready),    40'd0);
        check({tag, " block_reset"},    40'(block_reset),    40'd0);
        check({tag, " block_x_center"}, block_x_center,      40'd0);
        check({tag, " blocks_left"},    40'(blocks_left),    40'd0);
        check({tag, " hits"},           40'(hits),           40'd0);
        check({tag, " busy"},           40'(busy),           40'd0);
        check({tag, " level_done"},     40'(level_done),     40'd0);
    endtask

    // Directed stimulus.
    initial begin
        int n, n2, e;
        Reset       = 1'b1;
        start_level = 1'b0;
        level       = 4'd0;
        slot_done   = '0;
        slot_hit    = '0;
        repeat (3) @(negedge frame_clk);
        check_reset_values("reset");
        Reset = 1'b0;
        repeat (2) @(negedge frame_clk);

        // Level 0: gap 60, spawns 61 frames apart into slots 0..3.
        n = cyc + 1;
        push_spawn(n + 2,   0, 15);
        push_spawn(n + 63,  1, 14);
        push_spawn(n + 124, 2, 13);
        push_spawn(n + 185, 3, 12);
        start_level = 1'b1;
        level       = 4'd0;
        @(negedge frame_clk);
        start_level = 1'b0;
        check("blocks_left after start", 40'(blocks_left), 40'd16);
        check("busy after start", 40'(busy), 40'd1);
        wait_until(n + 2);
        check("blocks_left first spawn", 40'(blocks_left), 40'd15);

        // A start during the level must not reload anything.
        wait_until(n + 10);
        start_level = 1'b1;
        level       = 4'd14;
        @(negedge frame_clk);
        start_level = 1'b0;
        level       = 4'd0;
        wait_until(n + 12);
        check("blocks_left ignores start", 40'(blocks_left), 40'd15);
        wait_until(n + 63);
        check("blocks_left second spawn", 40'(blocks_left), 40'd14);

        // All slots full: FSM holds in SPAWN.
        wait_until(n + 250);
        check("all slots active", 40'(block_ready), 40'hF);
        check("blocks_left held", 40'(blocks_left), 40'd12);

        // Retire slot 2: reset pulse next cycle, respawn the cycle after.
        push_rst(n + 262, 2);
        push_spawn(n + 263, 2, 11);
        wait_until(n + 260);
        slot_done[2] = 1'b1;
        @(negedge frame_clk);
        slot_done = '0;
        check("slot2 ready cleared", 40'(block_ready[2]), 40'd0);

        // Hit and done together on slot 1: one hit, one reset pulse.
        push_rst(n + 272, 1);
        push_spawn(n + 324, 1, 10);
        wait_until(n + 270);
        slot_hit[1]  = 1'b1;
        slot_done[1] = 1'b1;
        @(negedge frame_clk);
        slot_hit  = '0;
        slot_done = '0;
        check("hits after double retire", 40'(hits), 40'(HIT_UNIT));

        // Hit sampled on the spawn edge of slot 1 is ignored.
        wait_until(n + 323);
        slot_hit[1] = 1'b1;
        @(negedge frame_clk);
        slot_hit = '0;
        wait_until(n + 326);
        check("spawn-edge hit ignored ready", 40'(block_ready), 40'hF);
        check("spawn-edge hit ignored hits", 40'(hits), 40'(HIT_UNIT));

        // Retire slot 0, then reset mid-level with 3 slots active.
        push_rst(n + 332, 0);
        wait_until(n + 330);
        slot_done[0] = 1'b1;
        @(negedge frame_clk);
        slot_done = '0;
        wait_until(n + 335);
        check("three slots active", 40'(block_ready), 40'hE);
        check("busy mid-level", 40'(busy), 40'd1);
        Reset = 1'b1;
        @(negedge frame_clk);
        check_reset_values("mid-level reset");
        Reset = 1'b0;

        // Level 14: gap floors at 8; each block retired 4 frames after spawn,
        // so slot 0 is always the one reused.
        wait_until(n + 340);
        n2 = cyc + 1;
        for (int k = 0; k < 16; k++) begin
            push_spawn(n2 + 2 + 9 * k, 0, 15 - k);
            push_rst(n2 + 7 + 9 * k, 0);
        end
        done_q.push_back(n2 + 147);
        start_level = 1'b1;
        level       = 4'd14;
        @(negedge frame_clk);
        start_level = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e = n2 + 2 + 9 * k;
            wait_until(e + 3);
            if (k % 2 == 1) slot_hit[0] = 1'b1;
            else            slot_done[0] = 1'b1;
            @(negedge frame_clk);
            slot_hit  = '0;
            slot_done = '0;
            if (k == 5) begin
                start_level = 1'b1;
                @(negedge frame_clk);
                start_level = 1'b0;
            end
        end
        wait_until(n2 + 150);
        check("level hits total", 40'(hits), 40'(8 * HIT_UNIT));
        check("busy after level", 40'(busy), 40'd0);
        check("blocks_left after level", 40'(blocks_left), 40'd0);
        check("spawn queue drained", 40'(spawn_q.size()), 40'd0);
        check("reset queue drained", 40'(rst_cyc_q.size()), 40'd0);
        check("done queue drained", 40'(done_q.size()), 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
